// File: rtl/seg_pkg.sv
// Shared 7-segment constants: active-low hex glyph table, blank/error glyphs, scan states.
package seg_pkg;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_ERR   = 7'b0101111;

    // Index 0 is the rightmost element; bit6 = g ... bit0 = a
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder; invalid digits render the error glyph.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       valid,
    output logic [6:0] glyph
);

    assign glyph = valid ? HEX_GLYPH[nibble] : GLYPH_ERR;

endmodule

// File: rtl/seg_scan_4digit.sv
// 4-digit common-anode 7-segment scanner with shadow registers and registered outputs.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_4digit
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = $clog2(REFRESH_DIV + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        blank,
    input  logic [15:0] value,
    input  logic [3:0]  digit_valid,
    input  logic [3:0]  dp_in,
    output logic [6:0]  g_to_a,
    output logic [3:0]  an,
    output logic        dp
);

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      value_q;
    logic [3:0]       valid_q;
    logic [3:0]       dp_q;

    logic [3:0] cur_nib;
    logic [6:0] cur_glyph;
    logic       lz_blank;
    logic       div_last;

    assign cur_nib  = value_q[4*idx +: 4];
    assign div_last = (div_cnt == DIV_W'(REFRESH_DIV - 1));

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .valid  (valid_q[idx]),
        .glyph  (cur_glyph)
    );

`ifdef SEG_LZ_BLANK_EN
    // zero_run[k]: digit k and every digit above it are valid zeros
    logic [3:0] zero_run;
    always_comb begin
        zero_run    = '0;
        zero_run[3] = valid_q[3] && (value_q[15:12] == 4'h0);
        zero_run[2] = zero_run[3] && valid_q[2] && (value_q[11:8] == 4'h0);
        zero_run[1] = zero_run[2] && valid_q[1] && (value_q[7:4]  == 4'h0);
        zero_run[0] = zero_run[1] && valid_q[0] && (value_q[3:0]  == 4'h0);
    end
    assign lz_blank = (idx != 2'd0) && zero_run[idx];
`else
    assign lz_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            idx     <= '0;
            value_q <= '0;
            valid_q <= '0;
            dp_q    <= '0;
            an      <= 4'b1111;
            g_to_a  <= GLYPH_BLANK;
            dp      <= 1'b1;
        end else if (blank) begin
            // blank wins over a simultaneous load; shadow registers keep their contents
            state   <= IDLE;
            div_cnt <= '0;
            idx     <= '0;
            an      <= 4'b1111;
            g_to_a  <= GLYPH_BLANK;
            dp      <= 1'b1;
        end else begin
            if (load) begin
                value_q <= value;
                valid_q <= digit_valid;
                dp_q    <= dp_in;
            end
            case (state)
                IDLE: begin
                    an     <= 4'b1111;
                    g_to_a <= GLYPH_BLANK;
                    dp     <= 1'b1;
                    if (load) begin
                        state   <= SCAN;
                        div_cnt <= '0;
                        idx     <= '0;
                    end
                end
                SCAN: begin
                    an     <= ~(4'b0001 << idx);
                    g_to_a <= lz_blank ? GLYPH_BLANK : cur_glyph;
                    dp     <= lz_blank ? 1'b1 : ~dp_q[idx];
                    if (div_last) begin
                        div_cnt <= '0;
                        idx     <= idx + 2'd1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
